// File: rtl/vgm_sn_sequencer_if.sv
// Byte-stream and PSG register-write bundle for vgm_sn_sequencer.
// master: stream source / PSG sink side; slave: the sequencer.
interface vgm_sn_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] out_reg;
    logic [7:0] out_val;
    logic       out_wr;

    modport master (
        output in_data,
        output in_valid,
        input  out_ready,
        input  out_reg,
        input  out_val,
        input  out_wr
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_ready,
        output out_reg,
        output out_val,
        output out_wr
    );
endinterface

// File: rtl/vgm_sn_sequencer.sv
// VGM command sequencer feeding the sn76489 register-write port with sample-accurate waits.
// Optional VGM_SKIP_UNKNOWN_EN: skip unknown opcodes with their operands instead of erroring.
module vgm_sn_sequencer #(
    parameter int unsigned CLK_PER_SAMPLE = 567
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    vgm_sn_sequencer_if.slave bus,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_error
);

    localparam int unsigned     DivW    = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_PER_SAMPLE - 1);

    typedef enum logic [3:0] {
        StIdle,
        StFetchOp,
        StFetchA0,
        StFetchA1,
        StWrite,
        StWrGap,
        StWait,
`ifdef VGM_SKIP_UNKNOWN_EN
        StSkip,
`endif
        StDone,
        StError
    } state_e;

    state_e          state_q;
    logic [7:0]      op_q;
    logic [7:0]      lo_q;
    logic [2:0]      latch_q;
    logic [15:0]     samples_q;
    logic [DivW-1:0] div_q;
    logic [3:0]      reg_q;
    logic [7:0]      val_q;
    logic            wr_q;
    logic            ready;
    logic            hs;
    logic [15:0]     arg_n;

`ifdef VGM_SKIP_UNKNOWN_EN
    logic [2:0] skip_q;

    function automatic logic [2:0] skip_len(input logic [7:0] op);
        logic [2:0] n;
        n = 3'd0;
        if ((op >= 8'h30 && op <= 8'h3F) || op == 8'h4F) begin
            n = 3'd1;
        end else if ((op >= 8'h40 && op <= 8'h4E) || (op >= 8'h51 && op <= 8'h5F) ||
                     (op >= 8'hA0 && op <= 8'hBF)) begin
            n = 3'd2;
        end else if (op >= 8'hC0 && op <= 8'hDF) begin
            n = 3'd3;
        end else if (op >= 8'hE0) begin
            n = 3'd4;
        end
        return n;
    endfunction
`endif

    always_comb begin
        ready = 1'b0;
        if (state_q == StFetchOp || state_q == StFetchA0 || state_q == StFetchA1) begin
            ready = 1'b1;
        end
`ifdef VGM_SKIP_UNKNOWN_EN
        if (state_q == StSkip) begin
            ready = 1'b1;
        end
`endif
    end

    assign hs    = bus.in_valid && ready;
    assign arg_n = {bus.in_data, lo_q};

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q   <= StIdle;
            op_q      <= 8'h00;
            lo_q      <= 8'h00;
            latch_q   <= 3'd0;
            samples_q <= 16'd0;
            div_q     <= '0;
            reg_q     <= 4'd0;
            val_q     <= 8'h00;
            wr_q      <= 1'b0;
`ifdef VGM_SKIP_UNKNOWN_EN
            skip_q    <= 3'd0;
`endif
        end else begin
            wr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_start) begin
                        state_q <= StFetchOp;
                    end
                end
                StFetchOp: begin
                    if (hs) begin
                        op_q <= bus.in_data;
                        unique casez (bus.in_data)
                            8'h50, 8'h61: state_q <= StFetchA0;
                            8'h62: begin
                                samples_q <= 16'd735;
                                div_q     <= '0;
                                state_q   <= StWait;
                            end
                            8'h63: begin
                                samples_q <= 16'd882;
                                div_q     <= '0;
                                state_q   <= StWait;
                            end
                            8'b0111_????: begin
                                samples_q <= {12'd0, bus.in_data[3:0]} + 16'd1;
                                div_q     <= '0;
                                state_q   <= StWait;
                            end
                            8'h66: state_q <= StDone;
                            default: begin
`ifdef VGM_SKIP_UNKNOWN_EN
                                if (skip_len(bus.in_data) != 3'd0) begin
                                    skip_q  <= skip_len(bus.in_data);
                                    state_q <= StSkip;
                                end else begin
                                    state_q <= StError;
                                end
`else
                                state_q <= StError;
`endif
                            end
                        endcase
                    end
                end
                StFetchA0: begin
                    if (hs) begin
                        if (op_q == 8'h50) begin
                            // Register index comes from a latch byte, else from the last latch.
                            val_q <= bus.in_data;
                            wr_q  <= 1'b1;
                            if (bus.in_data[7]) begin
                                latch_q <= bus.in_data[6:4];
                                reg_q   <= {1'b0, bus.in_data[6:4]};
                            end else begin
                                reg_q   <= {1'b0, latch_q};
                            end
                            state_q <= StWrite;
                        end else begin
                            lo_q    <= bus.in_data;
                            state_q <= StFetchA1;
                        end
                    end
                end
                StFetchA1: begin
                    if (hs) begin
                        if (arg_n == 16'd0) begin
                            state_q <= StFetchOp;
                        end else begin
                            samples_q <= arg_n;
                            div_q     <= '0;
                            state_q   <= StWait;
                        end
                    end
                end
                StWrite: state_q <= StWrGap;
                StWrGap: state_q <= StFetchOp;
                StWait: begin
                    if (div_q == DivLast) begin
                        div_q     <= '0;
                        samples_q <= samples_q - 16'd1;
                        if (samples_q == 16'd1) begin
                            state_q <= StFetchOp;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
`ifdef VGM_SKIP_UNKNOWN_EN
                StSkip: begin
                    if (hs) begin
                        skip_q <= skip_q - 3'd1;
                        if (skip_q == 3'd1) begin
                            state_q <= StFetchOp;
                        end
                    end
                end
`endif
                StDone:  state_q <= StDone;
                StError: state_q <= StError;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out_ready = ready;
    assign bus.out_reg   = reg_q;
    assign bus.out_val   = val_q;
    assign bus.out_wr    = wr_q;
    assign out_busy      = !(state_q == StIdle || state_q == StDone || state_q == StError);
    assign out_done      = (state_q == StDone);
    assign out_error     = (state_q == StError);

endmodule
